// File: rtl/bf16_int_cvt_if.sv
// Purpose: request/result bundle between the FPU issue stage and the int-to-bf16 converter.
// Latency: n/a (wires only).
// Backpressure: request side uses valid_i/ready_o; result side uses valid_o/ready_i.
// Ports: slave = converter side (valid_i, op_a_i, signed_i, flush_i, ready_i in;
//        ready_o, valid_o, result_o, inexact_o out); master = requester/consumer side.
interface bf16_int_cvt_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] op_a_i;
  logic        signed_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] result_o;
  logic        inexact_o;

  modport slave (
    input  valid_i, op_a_i, signed_i, flush_i, ready_i,
    output ready_o, valid_o, result_o, inexact_o
  );

  modport master (
    output valid_i, op_a_i, signed_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o, inexact_o
  );
endinterface

// File: rtl/bf16_int_cvt.sv
// Purpose: iterative 32-bit (signed/unsigned) integer to bfloat16 converter, RNE rounding.
// Latency: zero operand 1 cycle; otherwise 2 + number of NORM cycles (3 when bit 31 already set).
// Backpressure: one op in flight; ready_o only in IDLE, result held in DONE until ready_i.
// Ports: clk_i, rst_i (async, active-high); bus = bf16_int_cvt_if.slave carrying the
//        request (valid_i/ready_o/op_a_i/signed_i), flush_i, and result (valid_o/ready_i/result_o/inexact_o).
module bf16_int_cvt #(
  parameter int SHIFT_STEP = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  bf16_int_cvt_if.slave      bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [8:0] STEP9   = 9'(SHIFT_STEP);
  localparam logic [8:0] EXP_TOP = 9'd158; // bias 127 + 31: value of a 1 in bit 31

  logic [1:0]  state;
  logic [31:0] mag;
  logic [8:0]  exp;
  logic        sign;
  logic [15:0] result;
  logic        inexact;

  // Operand capture: magnitude of the operand; -2^31 naturally yields 0x8000_0000.
  logic        in_sign;
  logic [31:0] in_mag;
  assign in_sign = bus.signed_i & bus.op_a_i[31];
  assign in_mag  = in_sign ? (~bus.op_a_i + 32'd1) : bus.op_a_i;

  // Coarse shift is only safe when the whole top group is zero; otherwise step by one
  // so the leading one lands exactly in bit 31.
  logic coarse_ok;
  assign coarse_ok = (mag[31 -: SHIFT_STEP] == '0);

  // Round to nearest even on the normalized magnitude.
  logic       lsb, guard, sticky, up;
  logic [7:0] m8;
  logic [8:0] rnd_exp;
  logic [6:0] rnd_mant;
  assign lsb      = mag[24];
  assign guard    = mag[23];
  assign sticky   = |mag[22:0];
  assign up       = guard & (sticky | lsb);
  assign m8       = {1'b0, mag[30:24]} + {7'd0, up};
  // Mantissa carry-out means the value rounded up to the next power of two.
  assign rnd_exp  = exp + {8'd0, m8[7]};
  assign rnd_mant = m8[7] ? 7'd0 : m8[6:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      mag     <= '0;
      exp     <= '0;
      sign    <= 1'b0;
      result  <= '0;
      inexact <= 1'b0;
    end else if (bus.flush_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.valid_i) begin
            sign <= in_sign;
            mag  <= in_mag;
            exp  <= EXP_TOP;
            if (in_mag == 32'd0) begin
              result  <= 16'h0000;
              inexact <= 1'b0;
              state   <= ST_DONE;
            end else begin
              state <= ST_NORM;
            end
          end
        end
        ST_NORM: begin
          if (mag[31]) begin
            state <= ST_ROUND;
          end else if (coarse_ok) begin
            mag <= mag << SHIFT_STEP;
            exp <= exp - STEP9;
          end else begin
            mag <= mag << 1;
            exp <= exp - 9'd1;
          end
        end
        ST_ROUND: begin
          // Exponent stays within 127..159, so no overflow/denormal path exists.
          result  <= {sign, rnd_exp[7:0], rnd_mant};
          inexact <= guard | sticky;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready_o   = (state == ST_IDLE);
  assign bus.valid_o   = (state == ST_DONE);
  assign bus.result_o  = result;
  assign bus.inexact_o = inexact;

endmodule

// File: tb/tb_bf16_int_cvt.sv
// Purpose: self-checking bench for bf16_int_cvt (vector table + corner-case sequences).
// Latency: checks accept-to-valid latency on zero and bit-31-set operands.
// Backpressure: exercises held results (ready_i low), flush, and reset mid-operation.
module tb_bf16_int_cvt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bf16_int_cvt_if bus();

  bf16_int_cvt #(.SHIFT_STEP(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] op;
    logic        sgn;
    logic [15:0] res;
    logic        inex;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        inex;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Present a request and hold it until the converter accepts it. Returns just after the accept edge.
  task automatic send(input logic [31:0] op, input logic sgn);
    int n;
    n = 0;
    bus.op_a_i   = op;
    bus.signed_i = sgn;
    bus.valid_i  = 1'b1;
    while (!bus.ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_o) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
  endtask

  // Wait for valid_o, compare against the scoreboard head, optionally hold ready_i low, then consume.
  task automatic get_result(input string name, input int hold, output int lat);
    exp_t e;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.valid_o) break;
    end
    if (!bus.valid_o) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check({name, "_unexpected"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({name, "_res"}, {16'd0, bus.result_o}, {16'd0, e.res});
    check({name, "_inex"}, {31'd0, bus.inexact_o}, {31'd0, e.inex});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_res"}, {16'd0, bus.result_o}, {16'd0, e.res});
      check({name, "_hold_vld"}, {31'd0, bus.valid_o}, 32'd1);
      check({name, "_hold_rdy"}, {31'd0, bus.ready_o}, 32'd0);
    end
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_i = 1'b0;
    check({name, "_drop_vld"}, {31'd0, bus.valid_o}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{32'h0000_0001, 1'b0, 16'h3F80, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 1'b1, 16'hBF80, 1'b0};
    vecs[2]  = '{32'h0000_0000, 1'b0, 16'h0000, 1'b0};
    vecs[3]  = '{32'h0000_0101, 1'b0, 16'h4380, 1'b1}; // 257: tie, even stays
    vecs[4]  = '{32'h0000_0103, 1'b0, 16'h4382, 1'b1}; // 259: tie, odd rounds up
    vecs[5]  = '{32'hFFFF_FFFF, 1'b0, 16'h4F80, 1'b1}; // mantissa carry bumps exponent
    vecs[6]  = '{32'h8000_0000, 1'b1, 16'hCF00, 1'b0};
    vecs[7]  = '{32'h8000_0000, 1'b0, 16'h4F00, 1'b0};
    vecs[8]  = '{32'hFFFF_FFFD, 1'b1, 16'hC040, 1'b0}; // -3
    vecs[9]  = '{32'h7FFF_FFFF, 1'b1, 16'h4F00, 1'b1};
    vecs[10] = '{32'h0000_03E8, 1'b0, 16'h447A, 1'b0}; // 1000
    vecs[11] = '{32'h00FF_FFFF, 1'b0, 16'h4B80, 1'b1};
    vecs[12] = '{32'h0000_0180, 1'b0, 16'h43C0, 1'b0}; // 384
    vecs[13] = '{32'h0000_0000, 1'b1, 16'h0000, 1'b0};

    bus.valid_i  = 1'b0;
    bus.op_a_i   = '0;
    bus.signed_i = 1'b0;
    bus.flush_i  = 1'b0;
    bus.ready_i  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_result", {16'd0, bus.result_o}, 32'd0);
    check("rst_inexact", {31'd0, bus.inexact_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].op, vecs[i].sgn);
      sb.push_back('{vecs[i].res, vecs[i].inex});
      get_result($sformatf("vec%0d", i), 0, lat);
    end

    // Zero operand: valid one cycle after accept
    send(32'd0, 1'b0);
    sb.push_back('{16'h0000, 1'b0});
    get_result("zero_lat", 0, lat);
    check("zero_latency", lat, 32'd1);

    // -2^31: three cycles to valid, then held for 5 cycles with ready_i low
    send(32'h8000_0000, 1'b1);
    sb.push_back('{16'hCF00, 1'b0});
    get_result("min_hold", 5, lat);
    check("min_latency", lat, 32'd3);

    // Reset asserted mid-NORM drops the op
    send(32'd1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, bus.ready_o}, 32'd1);
    check("midrst_valid", {31'd0, bus.valid_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid_o) seen++;
    end
    check("midrst_no_output", seen, 32'd0);

    // Flush during ROUND with a new request held: flush wins, request accepted next cycle
    send(32'h8000_0000, 1'b0);          // now in NORM
    @(posedge clk);
    #1;                                  // now in ROUND
    bus.flush_i  = 1'b1;
    bus.op_a_i   = 32'h0000_03E8;
    bus.signed_i = 1'b0;
    bus.valid_i  = 1'b1;
    @(posedge clk);
    #1;
    check("flush_valid", {31'd0, bus.valid_o}, 32'd0);
    check("flush_idle", {31'd0, bus.ready_o}, 32'd1);
    bus.flush_i = 1'b0;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    check("flush_accept", {31'd0, bus.ready_o}, 32'd0);
    sb.push_back('{16'h447A, 1'b0});
    get_result("post_flush", 0, lat);
    check("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
